// File: rtl/dmb_fifo_pkg.sv
// dmb_fifo_pkg
//   Shared word type and constants for the DMB data FIFO responder model.
//   DMB_WORD_W : width of one FIFO word (18 bits)
//   dmb_word_t : one FIFO word
//   DMB_FILL   : default word driven on DATAOUT while output is disabled
package dmb_fifo_pkg;

  localparam int DMB_WORD_W = 18;

  typedef logic [17:0] dmb_word_t;

  localparam dmb_word_t DMB_FILL = 18'h3BAD3;

endpackage : dmb_fifo_pkg

// File: rtl/dmb_fifo_ram.sv
// dmb_fifo_ram
//   Simple dual-port storage for the DMB FIFO: synchronous write,
//   asynchronous read, depth 2^DEPTH_LOG2. Shaped for distributed RAM.
// Ports:
//   i_clk    : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : combinational read data at i_raddr
module dmb_fifo_ram
  import dmb_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  dmb_word_t             i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output dmb_word_t             o_rdata
);

  dmb_word_t r_mem [2**DEPTH_LOG2];

  // NOTE: storage has no reset; clearing it would block distributed-RAM
  // mapping, and the pointers/count alone decide which words are valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : dmb_fifo_ram

// File: rtl/dmb_fifo_responder.sv
// dmb_fifo_responder
//   Read-side model of an 18-bit DMB data FIFO answering the control
//   readout block: first-word-fall-through data, active-low read/output
//   enables, active-low "first word ready" flag and sticky error flags.
// Ports:
//   CLKDDU    : readout clock, all logic on rising edge
//   RST       : synchronous active-high reset (pointers, count, sticky flags)
//   FIFOMRST  : synchronous FIFO master reset (pointers, count only)
//   WE/WDATA  : producer write strobe and data
//   RENFIFO_B : active-low read enable, one pop per cycle
//   OEFIFO_B  : active-low output enable for DATAOUT
//   DATAOUT   : head word when enabled, FILL otherwise
//   FFOR_B    : low while at least one word is stored
//   FULL      : high when 2^DEPTH_LOG2 words are stored
//   WRDCNT    : stored word count
//   OVFL/UNFL : sticky write-while-full / read-while-empty
module dmb_fifo_responder
  import dmb_fifo_pkg::*;
#(
  parameter int        DEPTH_LOG2 = 8,
  parameter dmb_word_t FILL       = DMB_FILL
) (
  input  logic                CLKDDU,
  input  logic                RST,
  input  logic                FIFOMRST,
  input  logic                WE,
  input  dmb_word_t           WDATA,
  input  logic                RENFIFO_B,
  input  logic                OEFIFO_B,
  output dmb_word_t           DATAOUT,
  output logic                FFOR_B,
  output logic                FULL,
  output logic [DEPTH_LOG2:0] WRDCNT,
  output logic                OVFL,
  output logic                UNFL
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = CNT_ONE << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_ffor_b;
  logic                  r_ovfl;
  logic                  r_unfl;

  logic                  w_rd_req;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_ram_we;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  dmb_word_t             w_rd_data;

  // A read is only honoured when something is stored; a write into a full
  // FIFO is honoured only if the same cycle frees a slot.
  assign w_rd_req = ~RENFIFO_B;
  assign w_rd_ok  = w_rd_req && (r_count != CNT_ZERO);
  assign w_wr_ok  = WE && (!r_full || w_rd_ok);
  // Requests in a reset cycle must not touch storage either.
  assign w_ram_we = w_wr_ok && !RST && !FIFOMRST;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLKDDU) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ffor_b <= 1'b1;
      r_ovfl   <= 1'b0;
      r_unfl   <= 1'b0;
    end else if (FIFOMRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ffor_b <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count  <= w_count_nxt;
      // Flags registered from the next count so they move with the pointers.
      r_full   <= (w_count_nxt == CNT_FULL);
      r_ffor_b <= (w_count_nxt == CNT_ZERO);
      if (WE && !w_wr_ok)       r_ovfl <= 1'b1;
      if (w_rd_req && !w_rd_ok) r_unfl <= 1'b1;
    end
  end

  dmb_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (CLKDDU),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (WDATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign DATAOUT = OEFIFO_B ? FILL : w_rd_data;
  assign FFOR_B  = r_ffor_b;
  assign FULL    = r_full;
  assign WRDCNT  = r_count;
  assign OVFL    = r_ovfl;
  assign UNFL    = r_unfl;

endmodule : dmb_fifo_responder

// File: tb/tb_dmb_fifo_responder.sv
// tb_dmb_fifo_responder
//   Drives the same stimulus into two responders (depth 256 and depth 16)
//   and compares each against a queue-based model of a bounded FIFO.
module tb_dmb_fifo_responder;
  import dmb_fifo_pkg::*;

  typedef struct {
    int        dut;
    bit        chk_data;
    dmb_word_t data;
    bit        ffor_b;
    bit        full;
    int        cnt;
    bit        ovfl;
    bit        unfl;
  } exp_t;

  logic      CLKDDU = 1'b0;
  logic      RST = 1'b1;
  logic      FIFOMRST = 1'b0;
  logic      WE = 1'b0;
  dmb_word_t WDATA = '0;
  logic      RENFIFO_B = 1'b1;
  logic      OEFIFO_B = 1'b1;

  dmb_word_t  dout0, dout1;
  logic       ffor0, ffor1, full0, full1, ovfl0, ovfl1, unfl0, unfl1;
  logic [8:0] cnt0;
  logic [4:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t      sb[$];
  dmb_word_t mq[2][$];
  bit        mov[2];
  bit        mun[2];
  int        mdepth[2] = '{256, 16};

  always #5 CLKDDU = ~CLKDDU;

  dmb_fifo_responder #(.DEPTH_LOG2(8)) u_dut8 (
    .CLKDDU(CLKDDU), .RST(RST), .FIFOMRST(FIFOMRST), .WE(WE), .WDATA(WDATA),
    .RENFIFO_B(RENFIFO_B), .OEFIFO_B(OEFIFO_B), .DATAOUT(dout0), .FFOR_B(ffor0),
    .FULL(full0), .WRDCNT(cnt0), .OVFL(ovfl0), .UNFL(unfl0)
  );

  dmb_fifo_responder #(.DEPTH_LOG2(4)) u_dut4 (
    .CLKDDU(CLKDDU), .RST(RST), .FIFOMRST(FIFOMRST), .WE(WE), .WDATA(WDATA),
    .RENFIFO_B(RENFIFO_B), .OEFIFO_B(OEFIFO_B), .DATAOUT(dout1), .FFOR_B(ffor1),
    .FULL(full1), .WRDCNT(cnt1), .OVFL(ovfl1), .UNFL(unfl1)
  );

  task automatic check(input string name, input int dut,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, dut, act, exp, $time);
    end
  endtask

  // Expected visible outputs for the current cycle, taken from the model
  // state left by the previous edge plus the current output enable.
  task automatic push_expect(input logic oe_b);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.dut      = k;
      e.cnt      = mq[k].size();
      e.ffor_b   = (e.cnt == 0);
      e.full     = (e.cnt == mdepth[k]);
      e.ovfl     = mov[k];
      e.unfl     = mun[k];
      e.chk_data = oe_b || (e.cnt > 0);
      e.data     = oe_b ? DMB_FILL : ((e.cnt > 0) ? mq[k][0] : '0);
      sb.push_back(e);
    end
  endtask

  // Bounded-FIFO behaviour: reset clears, a pop frees a slot before the
  // push is considered, refused requests raise the sticky flags.
  task automatic model_step(input logic we, input dmb_word_t wd,
                            input logic ren_b, input logic rst, input logic mrst);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mov[k] = 1'b0;
        mun[k] = 1'b0;
      end else if (mrst) begin
        mq[k].delete();
      end else begin
        bit rd_ok, wr_ok;
        rd_ok = !ren_b && (mq[k].size() > 0);
        if (rd_ok) void'(mq[k].pop_front());
        wr_ok = we && (mq[k].size() < mdepth[k]);
        if (wr_ok) mq[k].push_back(wd);
        if (we && !wr_ok) mov[k] = 1'b1;
        if (!ren_b && !rd_ok) mun[k] = 1'b1;
      end
    end
  endtask

  // One clock cycle: inputs applied just after a rising edge.
  task automatic cycle(input logic we, input dmb_word_t wd, input logic ren_b,
                       input logic oe_b, input logic rst, input logic mrst);
    WE = we; WDATA = wd; RENFIFO_B = ren_b; OEFIFO_B = oe_b;
    RST = rst; FIFOMRST = mrst;
    push_expect(oe_b);
    model_step(we, wd, ren_b, rst, mrst);
    @(posedge CLKDDU);
    #1;
  endtask

  task automatic idle(input logic oe_b);
    cycle(1'b0, '0, 1'b1, oe_b, 1'b0, 1'b0);
  endtask

  task automatic write_words(input int n, input dmb_word_t base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + dmb_word_t'(i), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every pending expectation against the DUT outputs
  // on the falling edge, well away from the rising edge.
  exp_t        m_e;
  logic [31:0] a_data, a_cnt;
  logic        a_ffor, a_full, a_ovfl, a_unfl;
  always @(negedge CLKDDU) begin
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      if (m_e.dut == 0) begin
        a_data = 32'(dout0); a_cnt = 32'(cnt0);
        a_ffor = ffor0; a_full = full0; a_ovfl = ovfl0; a_unfl = unfl0;
      end else begin
        a_data = 32'(dout1); a_cnt = 32'(cnt1);
        a_ffor = ffor1; a_full = full1; a_ovfl = ovfl1; a_unfl = unfl1;
      end
      if (m_e.chk_data) check("DATAOUT", m_e.dut, a_data, 32'(m_e.data));
      check("WRDCNT", m_e.dut, a_cnt, 32'(m_e.cnt));
      check("FFOR_B", m_e.dut, 32'(a_ffor), 32'(m_e.ffor_b));
      check("FULL",   m_e.dut, 32'(a_full), 32'(m_e.full));
      check("OVFL",   m_e.dut, 32'(a_ovfl), 32'(m_e.ovfl));
      check("UNFL",   m_e.dut, 32'(a_unfl), 32'(m_e.unfl));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Untracked first edge brings the DUTs out of power-up X.
    @(posedge CLKDDU);
    #1;

    // Reset held two cycles with a write pending: write must be ignored.
    cycle(1'b1, 18'h12345, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 18'h12345, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Fill 40 words, then drain with output enabled.
    write_words(40, 18'h10000);
    read_words(40);
    idle(1'b0);

    // Full and wrap on the small instance.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    write_words(17, 18'h20001);
    read_words(16);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 18'h21000 + dmb_word_t'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0);

    // Simultaneous read and write at count 3, then at count 0.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    write_words(3, 18'h30000);
    for (int i = 0; i < 10; i++) cycle(1'b1, 18'h30100 + dmb_word_t'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    read_words(3);
    cycle(1'b1, 18'h30200, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Master reset mid-stream after an overflow on both instances.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    write_words(257, 18'h04000);
    cycle(1'b1, 18'h05555, 1'b0, 1'b1, 1'b0, 1'b1);
    write_words(5, 18'h06000);
    cycle(1'b1, 18'h05555, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 18'h2ABCD, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Output gating: toggle OEFIFO_B with reads disabled.
    write_words(2, 18'h07000);
    for (int i = 0; i < 8; i++) idle(logic'(i[0]));

    // Randomized traffic with occasional master reset and reset.
    for (int i = 0; i < 500; i++) begin
      logic we, ren_b, oe_b, rst, mrst;
      we    = logic'($urandom_range(0, 1));
      ren_b = ($urandom_range(0, 2) == 0);
      oe_b  = ($urandom_range(0, 3) == 0);
      mrst  = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cycle(we, dmb_word_t'($urandom), ren_b, oe_b, rst, mrst);
    end
    idle(1'b1);

    @(negedge CLKDDU);
    #1;
    check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmb_fifo_responder
